sti_rx: RTL and testbench
=========================

# sti_rx

Serial receiver for the STI link. Sits directly downstream of the STI serializer: samples its `so_data`/`so_valid` stream and rebuilds each frame into a right-justified parallel word. Checks frame length against the configured length code. Buffers completed words in a small FIFO with a valid/ready output port for the checker or host side.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, minimum 2.

Ports:
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `si_data` input, 1 bit: serial bit; sampled only when `si_valid` = 1.
- `si_valid` input, 1 bit: high for every bit of a frame; a low cycle ends the frame.
- `cfg_msb` input, 1 bit: bit order; 1 = MSB first. Latched on the first bit of a frame.
- `cfg_length` input, 2 bits: expected length code; 0/1/2/3 = 8/16/24/32 bits. Latched with `cfg_msb`.
- `rx_data` output, 32 bits: head-of-FIFO word, right-justified, zero-extended.
- `rx_len` output, 6 bits: head-of-FIFO received bit count, 1..32.
- `rx_err` output, 1 bit: head-of-FIFO length mismatch flag.
- `rx_valid` output, 1 bit: FIFO non-empty.
- `rx_ready` input, 1 bit: consumer accepts the head entry when `rx_valid` = 1 and `rx_ready` = 1.
- `busy` output, 1 bit: high while the FSM is not in IDLE.
- `ovf` output, 1 bit: sticky; set when a frame is dropped because the FIFO is full.

## Operation

FSM states: IDLE, SHIFT, COMMIT.
- **IDLE**
  - `si_valid` = 1: capture the bit, set count to 1, latch `cfg_msb` and `cfg_length`, go to SHIFT.
- **SHIFT**
  - `si_valid` = 1: capture the bit, increment count.
  - `si_valid` = 0: go to COMMIT.
- **COMMIT**
  - Push {word, count, err} to the FIFO, then clear the assembly register.
  - `si_valid` = 1 in this cycle: the bit is the first bit of the next frame; relatch config, count = 1, go to SHIFT.
  - Otherwise go to IDLE.

Bit assembly:
- MSB-first: `word <= {word[30:0], bit}`.
- LSB-first: `word[count] <= bit`.
- Either way the result is right-justified; bits at and above the received count are 0.

Length check:
- `err` = (count ≠ 8×(`cfg_length`+1)), or more than 32 bits received.
- Bits beyond 32 are discarded. Count saturates at 33 internally; `rx_len` reports 32 in that case with `err` = 1.

FIFO:
- Simultaneous push and pop on a full FIFO is allowed; both take effect.
- Push with the FIFO full and no pop: the frame is dropped and `ovf` is set. `ovf` clears only on reset.
- Pop on an empty FIFO: ignored.

Reset mid-frame discards the partial frame and empties the FIFO.

Reset values:
- `rx_data` = 0, `rx_len` = 0, `rx_err` = 0.
- `rx_valid` = 0, `busy` = 0, `ovf` = 0.
- FSM in IDLE.

## Timing

- The last frame bit is sampled at edge t; `si_valid` is sampled low at edge t+1, moving the FSM to COMMIT.
- The FIFO write occurs at edge t+2. If the FIFO was empty, `rx_valid` is high after edge t+2 with the word on `rx_data`.
- FIFO pointers advance on the edge where `rx_valid` & `rx_ready`; the next head appears in the following cycle.
- Outputs are registered or direct FIFO reads; no combinational path from `si_*` to `rx_*`.
- Sustained throughput: one frame per (N+1) cycles minimum, including a back-to-back frame starting in COMMIT.

## Configuration

- Macro `STI_RX_STATS_EN`.
- When defined: adds outputs `stat_frames` [7:0] and `stat_errs` [7:0], both saturating counters. They increment in COMMIT on accepted frames and on accepted frames with `err` set, respectively. Both reset to 0.
- When undefined: the ports and counters are absent. All other behaviour is identical.

## Structure

- Package `sti_rx_pkg`:
  - FSM state typedef.
  - Length-code constants `LEN8`..`LEN32`.
  - Function `len_bits(code)` returning 8..32.
  - Width constants `WORD_W` = 32, `LEN_W` = 6.
- Sub-module `sti_rx_fifo`: synchronous FIFO, 39-bit entries (`FIFO_DEPTH` deep), with `full`/`empty` and an extra pointer bit for wrap detection.

## Test plan

- 8-bit MSB-first 0xA5, `cfg_length` = 0 → single `rx_valid` with `rx_data` = 0x000000A5, `rx_len` = 8, `rx_err` = 0, two cycles after `si_valid` falls.
- 16-bit LSB-first, bits for 0x1234, `cfg_length` = 1 → `rx_data` = 0x00001234, `rx_err` = 0.
- 24-bit stream with `cfg_length` = 3 → `rx_len` = 24, `rx_err` = 1. A 34-bit stream → `rx_len` = 32, `rx_err` = 1, the first 32 bits kept.
- `rx_ready` held 0, send 5 frames with `FIFO_DEPTH` = 4 → 4 stored in order, `ovf` = 1, the fifth dropped. Releasing `rx_ready` drains exactly 4 words.
- Frame immediately followed by a new frame whose first bit arrives in COMMIT → both words correct, no bit lost.
- `reset` asserted mid-SHIFT with 2 words queued → all outputs return to reset values, `rx_valid` = 0 after release.

Source files
------------

// File: rtl/sti_rx_pkg.sv
// Shared types, constants and helpers for the STI serial receiver.
package sti_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int WORD_W  = 32;
  localparam int LEN_W   = 6;
  localparam int ENTRY_W = WORD_W + LEN_W + 1;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  function automatic logic [LEN_W-1:0] len_bits(input logic [1:0] code);
    return {1'b0, code, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_fifo.sv
// Synchronous FIFO for received frames; extra pointer bit distinguishes full from empty.
module sti_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             push_ok,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: rebuilds frames into right-justified words and queues them.
// Optional STI_RX_STATS_EN adds saturating frame/error counters.
module sti_rx
  import sti_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              cfg_msb,
  input  logic [1:0]        cfg_length,
  output logic [WORD_W-1:0] rx_data,
  output logic [LEN_W-1:0]  rx_len,
  output logic              rx_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              ovf
`ifdef STI_RX_STATS_EN
  ,
  output logic [7:0]        stat_frames,
  output logic [7:0]        stat_errs
`endif
);

  state_t             state, next_state;
  logic [WORD_W-1:0]  word;
  logic [LEN_W-1:0]   count;
  logic               msb_l;
  logic [1:0]         len_l;
  logic               start, capture, push;
  logic [LEN_W-1:0]   commit_len;
  logic               commit_err;
  logic [ENTRY_W-1:0] head;
  logic               push_ok, fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    capture    = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (si_valid) begin
          start      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (si_valid) capture = 1'b1;
        else          next_state = COMMIT;
      end
      COMMIT: begin
        push = 1'b1;
        if (si_valid) begin
          start      = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Count runs to 33 so an over-long frame stays distinguishable from exactly 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
      msb_l <= 1'b0;
      len_l <= LEN8;
    end else if (start) begin
      word  <= {{(WORD_W-1){1'b0}}, si_data};
      count <= 6'd1;
      msb_l <= cfg_msb;
      len_l <= cfg_length;
    end else if (capture) begin
      if (count < 6'd32) begin
        if (msb_l) word <= {word[WORD_W-2:0], si_data};
        else       word[count[4:0]] <= si_data;
      end
      if (count < 6'd33) count <= count + 6'd1;
    end else if (push) begin
      word  <= '0;
      count <= '0;
    end
  end

  assign commit_len = (count > 6'd32) ? 6'd32 : count;
  assign commit_err = (count != len_bits(len_l)) || (count > 6'd32);

  sti_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  ({word, commit_len, commit_err}),
    .pop    (rx_ready),
    .rdata  (head),
    .push_ok(push_ok),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign rx_data  = head[ENTRY_W-1:LEN_W+1];
  assign rx_len   = head[LEN_W:1];
  assign rx_err   = head[0];
  assign rx_valid = !fifo_empty;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                ovf <= 1'b0;
    else if (push && !push_ok && fifo_full)    ovf <= 1'b1;
  end

`ifdef STI_RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else if (push_ok) begin
      if (stat_frames != 8'hFF)              stat_frames <= stat_frames + 8'd1;
      if (commit_err && stat_errs != 8'hFF)  stat_errs   <= stat_errs + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: directed table, corner sequences and random frames vs a queue model.
module tb_sti_rx;
  import sti_rx_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid, cfg_msb, rx_ready;
  logic [1:0]  cfg_length;
  logic [31:0] rx_data;
  logic [5:0]  rx_len;
  logic        rx_err, rx_valid, busy, ovf;
`ifdef STI_RX_STATS_EN
  logic [7:0]  stat_frames, stat_errs;
`endif

  always #5 clk = ~clk;

  sti_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_msb    (cfg_msb),
    .cfg_length (cfg_length),
    .rx_data    (rx_data),
    .rx_len     (rx_len),
    .rx_err     (rx_err),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .ovf        (ovf)
`ifdef STI_RX_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_errs  (stat_errs)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    logic        err;
  } entry_t;

  typedef struct {
    logic [63:0] val;
    int          n;
    logic        msb;
    logic [1:0]  len;
    logic [31:0] exp_data;
    logic [5:0]  exp_len;
    logic        exp_err;
  } vec_t;

  entry_t      mq[$];
  bit          cur_bits[$];
  logic [31:0] seen[$];
  bit          in_frame, commit_pend, ovf_m, busy_m, m_msb;
  logic [1:0]  m_len;
  entry_t      commit_e;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        tbl[7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level result of a frame: first 32 transmitted bits placed by bit order.
  function automatic entry_t frame_result();
    entry_t e;
    int n = cur_bits.size();
    int k = (n > 32) ? 32 : n;
    e.data = '0;
    for (int i = 0; i < k; i++) begin
      if (m_msb) e.data[k-1-i] = cur_bits[i];
      else       e.data[i]     = cur_bits[i];
    end
    e.len = 6'(k);
    e.err = (n != 8 * (int'(m_len) + 1)) || (n > 32);
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    cur_bits.delete();
    in_frame    = 0;
    commit_pend = 0;
    ovf_m       = 0;
    busy_m      = 0;
  endtask

  // One cycle: check outputs against the model, advance the model, drive inputs.
  task automatic apply_stimulus(input logic v, input logic d, input logic rdy);
    bit pop, full;
    @(negedge clk);
    check_output("rx_valid", rx_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_output("rx_data", rx_data, mq[0].data);
      check_output("rx_len", rx_len, mq[0].len);
      check_output("rx_err", rx_err, mq[0].err);
      if (rdy) seen.push_back(rx_data);
    end
    check_output("busy", busy, busy_m);
    check_output("ovf", ovf, ovf_m);
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (commit_pend) begin
      if (!full || pop) mq.push_back(commit_e);
      else              ovf_m = 1;
      commit_pend = 0;
    end
    busy_m = v || in_frame;
    if (v) begin
      if (!in_frame) begin
        cur_bits.delete();
        m_msb    = cfg_msb;
        m_len    = cfg_length;
        in_frame = 1;
      end
      cur_bits.push_back(d);
    end else if (in_frame) begin
      commit_e    = frame_result();
      commit_pend = 1;
      in_frame    = 0;
    end
    si_valid = v;
    si_data  = d;
    rx_ready = rdy;
  endtask

  task automatic send_frame(input logic [63:0] val, input int n, input logic msb,
                            input logic [1:0] len, input logic rdy);
    cfg_msb    = msb;
    cfg_length = len;
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b1, msb ? val[n-1-i] : val[i], rdy);
  endtask

  initial begin
    int got;
    tbl[0] = '{64'hA5,        8,  1'b1, 2'd0, 32'h000000A5, 6'd8,  1'b0};
    tbl[1] = '{64'h1234,      16, 1'b0, 2'd1, 32'h00001234, 6'd16, 1'b0};
    tbl[2] = '{64'hABCDEF,    24, 1'b1, 2'd3, 32'h00ABCDEF, 6'd24, 1'b1};
    tbl[3] = '{64'h312345678, 34, 1'b1, 2'd3, 32'hC48D159E, 6'd32, 1'b1};
    tbl[4] = '{64'hDEADBEEF,  32, 1'b0, 2'd3, 32'hDEADBEEF, 6'd32, 1'b0};
    tbl[5] = '{64'h1,         1,  1'b1, 2'd0, 32'h00000001, 6'd1,  1'b1};
    tbl[6] = '{64'h300000001, 34, 1'b0, 2'd3, 32'h00000001, 6'd32, 1'b1};

    reset = 1'b0; si_valid = 0; si_data = 0; rx_ready = 0; cfg_msb = 0; cfg_length = 0;
    model_reset();
    #12;
    check_output("reset rx_data", rx_data, 0);
    check_output("reset rx_len", rx_len, 0);
    check_output("reset rx_err", rx_err, 0);
    check_output("reset rx_valid", rx_valid, 0);
    check_output("reset busy", busy, 0);
    check_output("reset ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] directed table");
    for (int t = 0; t < 7; t++) begin
      send_frame(tbl[t].val, tbl[t].n, tbl[t].msb, tbl[t].len, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_output($sformatf("tbl%0d valid", t), rx_valid, 1);
      check_output($sformatf("tbl%0d data", t), rx_data, tbl[t].exp_data);
      check_output($sformatf("tbl%0d len", t), rx_len, tbl[t].exp_len);
      check_output($sformatf("tbl%0d err", t), rx_err, tbl[t].exp_err);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] overflow");
    for (int f = 0; f < 5; f++) begin
      send_frame(64'h10 + 64'(f), 8, 1'b1, 2'd0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("ovf after 5 frames", ovf, 1);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1);
      if (rx_valid) begin
        check_output("drain order", rx_data, 32'h10 + 32'(got));
        got++;
      end
    end
    check_output("drain count", got, 4);

    $display("[TB] back-to-back");
    seen.delete();
    send_frame(64'h3C, 8, 1'b1, 2'd0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    send_frame(64'hBEEF, 16, 1'b0, 2'd1, 1'b1);
    repeat (5) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("b2b count", seen.size(), 2);
    if (seen.size() == 2) begin
      check_output("b2b word0", seen[0], 32'h3C);
      check_output("b2b word1", seen[1], 32'hBEEF);
    end

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(34, 1);
      logic [63:0] val = {$urandom, $urandom};
      logic msb = 1'($urandom);
      logic [1:0] len = 2'($urandom);
      cfg_msb = msb;
      cfg_length = len;
      for (int i = 0; i < n; i++)
        apply_stimulus(1'b1, val[i], $urandom_range(3, 0) != 0);
      repeat ($urandom_range(3, 1)) apply_stimulus(1'b0, 1'b0, $urandom_range(3, 0) != 0);
    end
    repeat (10) apply_stimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-frame");
    send_frame(64'h81, 8, 1'b1, 2'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    send_frame(64'h42, 8, 1'b0, 2'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("pre-reset valid", rx_valid, 1);
    check_output("pre-reset busy", busy, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output("mid reset rx_data", rx_data, 0);
    check_output("mid reset rx_len", rx_len, 0);
    check_output("mid reset rx_err", rx_err, 0);
    check_output("mid reset rx_valid", rx_valid, 0);
    check_output("mid reset busy", busy, 0);
    check_output("mid reset ovf", ovf, 0);
    si_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1);
    send_frame(64'h5A, 8, 1'b1, 2'd0, 1'b1);
    repeat (4) apply_stimulus(1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
